// File: rtl/proc_multicycle.sv
// Multicycle 16-bit processor: eight registers (R7 = PC), single shared bus, 3-5 cycles per instruction.
// Optional SLL/SRL opcodes are built in only when PROC_SHIFT_EN is defined.
module proc_multicycle (
    input  logic         clk,
    input  logic         Resetn,
    input  logic         Run,
    input  logic [15:0]  DIN,
    output logic [15:0]  ADDRout,
    output logic [15:0]  DOUTout,
    output logic         memW,
    output logic         muxRomRam,
    output logic [127:0] oREGS
);

    // step | meaning
    // T0   | ADDR <= PC, PC <= PC+1
    // T1   | IR <= DIN[9:0]
    // T2   | LD/ST address, MV/MVNZ move, MVI immediate fetch, ALU A <= RX
    // T3   | LD/MVI write RX, ST DOUT <= RX, ALU G <= A op RY
    // T4   | ST write strobe, ALU RX <= G
    typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_t;

    localparam logic [3:0] OP_LD   = 4'h0;
    localparam logic [3:0] OP_ST   = 4'h1;
    localparam logic [3:0] OP_MVNZ = 4'h2;
    localparam logic [3:0] OP_MV   = 4'h3;
    localparam logic [3:0] OP_MVI  = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_SLT  = 4'h8;
    localparam logic [3:0] OP_SLL  = 4'h9;
    localparam logic [3:0] OP_SRL  = 4'hA;

    step_t             step_q, step_d;
    logic              running_q, running_d;
    logic [7:0][15:0]  r_q, r_d;
    logic [15:0]       a_q, a_d;
    logic [15:0]       g_q, g_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       dout_q, dout_d;
    logic [9:0]        ir_q, ir_d;

    logic        active;
    logic [3:0]  opcode;
    logic [7:0]  x_oh, y_oh;
    logic        is_alu;
    logic [7:0]  r_out, r_in;
    logic        din_out, g_out;
    logic        a_in, g_in, addr_in, dout_in, ir_in, pc_inc, done;
    logic        mem_w, mux_rom_ram;
    logic [15:0] bus;
    logic [15:0] alu_res;

    // The edge that samples Run high already executes T0.
    assign active    = running_q | Run;
    assign running_d = running_q | Run;

    assign opcode = ir_q[9:6];
    assign x_oh   = 8'b0000_0001 << ir_q[5:3];
    assign y_oh   = 8'b0000_0001 << ir_q[2:0];

`ifdef PROC_SHIFT_EN
    assign is_alu = (opcode >= OP_ADD) && (opcode <= OP_SRL);
`else
    assign is_alu = (opcode >= OP_ADD) && (opcode <= OP_SLT);
`endif

    always_comb begin
        step_d      = T0;
        r_out       = 8'h00;
        r_in        = 8'h00;
        din_out     = 1'b0;
        g_out       = 1'b0;
        a_in        = 1'b0;
        g_in        = 1'b0;
        addr_in     = 1'b0;
        dout_in     = 1'b0;
        ir_in       = 1'b0;
        pc_inc      = 1'b0;
        done        = 1'b0;
        mem_w       = 1'b0;
        mux_rom_ram = 1'b0;
        if (active) begin
            case (step_q)
                T0: begin
                    r_out[7] = 1'b1;
                    addr_in  = 1'b1;
                    pc_inc   = 1'b1;
                    step_d   = T1;
                end
                T1: begin
                    din_out = 1'b1;
                    ir_in   = 1'b1;
                    step_d  = T2;
                end
                T2: begin
                    step_d = T3;
                    case (opcode)
                        OP_LD, OP_ST: begin
                            r_out   = y_oh;
                            addr_in = 1'b1;
                        end
                        OP_MVNZ: begin
                            if (g_q != 16'h0000) begin
                                r_out = y_oh;
                                r_in  = x_oh;
                            end
                            done = 1'b1;
                        end
                        OP_MV: begin
                            r_out = y_oh;
                            r_in  = x_oh;
                            done  = 1'b1;
                        end
                        OP_MVI: begin
                            r_out[7] = 1'b1;
                            addr_in  = 1'b1;
                            pc_inc   = 1'b1;
                        end
                        default: begin
                            if (is_alu) begin
                                r_out = x_oh;
                                a_in  = 1'b1;
                            end else begin
                                done = 1'b1;
                            end
                        end
                    endcase
                end
                T3: begin
                    step_d = T4;
                    case (opcode)
                        OP_LD: begin
                            din_out     = 1'b1;
                            r_in        = x_oh;
                            mux_rom_ram = 1'b1;
                            done        = 1'b1;
                        end
                        OP_ST: begin
                            r_out   = x_oh;
                            dout_in = 1'b1;
                        end
                        OP_MVI: begin
                            din_out = 1'b1;
                            r_in    = x_oh;
                            done    = 1'b1;
                        end
                        default: begin
                            if (is_alu) begin
                                r_out = y_oh;
                                g_in  = 1'b1;
                            end else begin
                                done = 1'b1;
                            end
                        end
                    endcase
                end
                T4: begin
                    done = 1'b1;
                    if (opcode == OP_ST) begin
                        mem_w = 1'b1;
                    end else if (is_alu) begin
                        g_out = 1'b1;
                        r_in  = x_oh;
                    end
                end
                default: done = 1'b1;
            endcase
            if (done) begin
                step_d = T0;
            end
        end
    end

    // Bus priority: DIN over G over the selected register; nothing selected reads as 0.
    always_comb begin
        bus = 16'h0000;
        if (din_out) begin
            bus = DIN;
        end else if (g_out) begin
            bus = g_q;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (r_out[i]) begin
                    bus = r_q[i];
                end
            end
        end
    end

    always_comb begin
        alu_res = 16'h0000;
        case (opcode)
            OP_ADD:  alu_res = a_q + bus;
            OP_SUB:  alu_res = a_q - bus;
            OP_OR:   alu_res = a_q | bus;
            OP_SLT:  alu_res = {15'h0000, (a_q < bus)};
`ifdef PROC_SHIFT_EN
            OP_SLL:  alu_res = (bus > 16'd15) ? 16'h0000 : (a_q << bus[3:0]);
            OP_SRL:  alu_res = (bus > 16'd15) ? 16'h0000 : (a_q >> bus[3:0]);
`endif
            default: alu_res = 16'h0000;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            r_d[i] = r_in[i] ? bus : r_q[i];
        end
        // A bus write to R7 is a jump and overrides the increment.
        if (pc_inc && !r_in[7]) begin
            r_d[7] = r_q[7] + 16'd1;
        end
        a_d    = a_in    ? bus       : a_q;
        g_d    = g_in    ? alu_res   : g_q;
        addr_d = addr_in ? bus       : addr_q;
        dout_d = dout_in ? bus       : dout_q;
        ir_d   = ir_in   ? bus[9:0]  : ir_q;
    end

    always_ff @(posedge clk or posedge Resetn) begin
        if (Resetn) begin
            step_q    <= T0;
            running_q <= 1'b0;
            r_q       <= '0;
            a_q       <= 16'h0000;
            g_q       <= 16'h0000;
            addr_q    <= 16'h0000;
            dout_q    <= 16'h0000;
            ir_q      <= 10'h000;
        end else begin
            step_q    <= step_d;
            running_q <= running_d;
            r_q       <= r_d;
            a_q       <= a_d;
            g_q       <= g_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            ir_q      <= ir_d;
        end
    end

    assign ADDRout   = addr_q;
    assign DOUTout   = dout_q;
    assign memW      = mem_w;
    assign muxRomRam = mux_rom_ram;
    assign oREGS     = r_q;

endmodule

// File: tb/tb_proc_multicycle.sv
// Bench for proc_multicycle: ROM/RAM model around the DUT, ALU vector table,
// hand-written multicycle sequences and random programs against an instruction-level model.
`timescale 1ns/1ps
module tb_proc_multicycle;

    logic         clk = 1'b0;
    logic         Resetn = 1'b0;
    logic         Run = 1'b0;
    logic [15:0]  DIN;
    logic [15:0]  ADDRout;
    logic [15:0]  DOUTout;
    logic         memW;
    logic         muxRomRam;
    logic [127:0] oREGS;

    logic [15:0] rom [256];
    logic [15:0] ram [256];
    logic [15:0] prog [$];

    logic [15:0] m_r [8];
    logic [15:0] m_g;
    logic [15:0] m_ram [256];

    int n_checks = 0;
    int n_errors = 0;

    proc_multicycle dut (
        .clk       (clk),
        .Resetn    (Resetn),
        .Run       (Run),
        .DIN       (DIN),
        .ADDRout   (ADDRout),
        .DOUTout   (DOUTout),
        .memW      (memW),
        .muxRomRam (muxRomRam),
        .oREGS     (oREGS)
    );

    always #5 clk = ~clk;

    assign DIN = muxRomRam ? ram[ADDRout[7:0]] : rom[ADDRout[7:0]];

    always @(posedge clk) begin
        if (memW) ram[ADDRout[7:0]] <= DOUTout;
    end

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [$];

`ifdef PROC_SHIFT_EN
    localparam logic [15:0] E_SLL_4  = 16'h0030;
    localparam logic [15:0] E_SLL_16 = 16'h0000;
    localparam logic [15:0] E_SRL_15 = 16'h0001;
    localparam logic [15:0] E_SRL_20 = 16'h0000;
`else
    localparam logic [15:0] E_SLL_4  = 16'h0003;
    localparam logic [15:0] E_SLL_16 = 16'h0001;
    localparam logic [15:0] E_SRL_15 = 16'h8000;
    localparam logic [15:0] E_SRL_20 = 16'h8000;
`endif

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] reg_of(input int i);
        return oREGS[16*i +: 16];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) rom[i] = 16'h03FF;
        for (int i = 0; i < prog.size(); i++) rom[i] = prog[i];
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 256; i++) ram[i] <= 16'h0000;
    endtask

    // Reset, then leave Run high so the next rising edge executes T0.
    task automatic restart();
        @(negedge clk);
        Resetn = 1'b1;
        Run    = 1'b0;
        @(negedge clk);
        Resetn = 1'b0;
        Run    = 1'b1;
    endtask

    // Instruction-level reference: executes one instruction, returns its cycle count.
    task automatic model_exec(output int cyc);
        logic [15:0] w, a, b, res;
        logic        alu;
        int          x, y;
        w = rom[m_r[7][7:0]];
        m_r[7] = m_r[7] + 16'd1;
        x = int'(w[5:3]);
        y = int'(w[2:0]);
        a = m_r[x];
        b = m_r[y];
        res = 16'h0000;
        alu = 1'b0;
        cyc = 3;
        case (w[9:6])
            4'h0: begin m_r[x] = m_ram[b[7:0]]; cyc = 4; end
            4'h1: begin m_ram[b[7:0]] = a; cyc = 5; end
            4'h2: if (m_g != 16'h0000) m_r[x] = b;
            4'h3: m_r[x] = b;
            4'h4: begin
                res = rom[m_r[7][7:0]];
                m_r[7] = m_r[7] + 16'd1;
                m_r[x] = res;
                cyc = 4;
            end
            4'h5: begin res = a + b; alu = 1'b1; end
            4'h6: begin res = a - b; alu = 1'b1; end
            4'h7: begin res = a | b; alu = 1'b1; end
            4'h8: begin res = (a < b) ? 16'd1 : 16'd0; alu = 1'b1; end
`ifdef PROC_SHIFT_EN
            4'h9: begin res = (b >= 16) ? 16'd0 : 16'(a << b); alu = 1'b1; end
            4'hA: begin res = (b >= 16) ? 16'd0 : 16'(a >> b); alu = 1'b1; end
`endif
            default: cyc = 3;
        endcase
        if (alu) begin
            m_g = res;
            m_r[x] = res;
            cyc = 5;
        end
    endtask

    initial begin
        logic [127:0] exp_regs;
        int cyc, diffs;

        // Reset values, asserted asynchronously before any clock edge
        #1 Resetn = 1'b1;
        #2;
        check("rst_oregs", oREGS, 128'h0);
        check("rst_addr", ADDRout, 16'h0);
        check("rst_dout", DOUTout, 16'h0);
        check("rst_memw", memW, 1'b0);
        check("rst_mux", muxRomRam, 1'b0);

        // MVI R0,2; MVI R1,3; ADD R1,R0 with a single Run pulse
        clear_ram();
        prog = '{16'h0100, 16'h0002, 16'h0108, 16'h0003, 16'h0148};
        load_prog();
        @(negedge clk);
        Resetn = 1'b0;
        tick(3);
        check("idle_pc", reg_of(7), 16'h0);
        @(negedge clk);
        Run = 1'b1;
        tick(1);
        Run = 1'b0;
        tick(12);
        check("add_r0", reg_of(0), 16'h0002);
        check("add_r1", reg_of(1), 16'h0005);
        check("add_r7", reg_of(7), 16'h0005);

        // Reset during T3 of the ADD, then resume from address 0
        restart();
        tick(11);
        Run = 1'b0;
        check("pre_abort_r1", reg_of(1), 16'h0003);
        #2 Resetn = 1'b1;
        #1;
        check("abort_oregs", oREGS, 128'h0);
        check("abort_addr", ADDRout, 16'h0);
        check("abort_dout", DOUTout, 16'h0);
        check("abort_memw", memW, 1'b0);
        check("abort_mux", muxRomRam, 1'b0);
        @(negedge clk);
        Resetn = 1'b0;
        tick(2);
        check("abort_idle_pc", reg_of(7), 16'h0);
        @(negedge clk);
        Run = 1'b1;
        tick(13);
        check("resume_r0", reg_of(0), 16'h0002);
        check("resume_r1", reg_of(1), 16'h0005);
        check("resume_r7", reg_of(7), 16'h0005);

        // LD R2,R3 with R3=3: RAM sourced only in T3
        clear_ram();
        ram[3] <= 16'h0004;
        prog = '{16'h0118, 16'h0003, 16'h0013};
        load_prog();
        restart();
        tick(4);
        for (int c = 4; c <= 7; c++) begin
            check($sformatf("ld_mux_c%0d", c), muxRomRam, (c == 7));
            if (c == 7) check("ld_addr", ADDRout, 16'h0003);
            tick(1);
        end
        check("ld_mux_after", muxRomRam, 1'b0);
        check("ld_r2", reg_of(2), 16'h0004);

        // ST R2,R0 with R2=7, R0=0: write strobe only in T4
        clear_ram();
        prog = '{16'h0110, 16'h0007, 16'h0100, 16'h0000, 16'h0050};
        load_prog();
        restart();
        tick(8);
        for (int c = 8; c <= 12; c++) begin
            check($sformatf("st_memw_c%0d", c), memW, (c == 12));
            if (c == 12) begin
                check("st_addr", ADDRout, 16'h0000);
                check("st_dout", DOUTout, 16'h0007);
            end
            tick(1);
        end
        check("st_memw_after", memW, 1'b0);
        check("st_ram0", ram[0], 16'h0007);

        // MVNZ with G=0 (no move, 3 cycles), then with G=2 after SUB
        prog = '{16'h0110, 16'h0009, 16'h0082, 16'h0108, 16'h0005,
                 16'h0118, 16'h0003, 16'h018B, 16'h0082};
        load_prog();
        restart();
        tick(7);
        check("mvnz_g0_r0", reg_of(0), 16'h0000);
        check("mvnz_g0_r7", reg_of(7), 16'h0003);
        tick(1);
        check("mvnz_3cyc_r7", reg_of(7), 16'h0004);
        tick(15);
        check("mvnz_sub_r1", reg_of(1), 16'h0002);
        check("mvnz_g2_r0", reg_of(0), 16'h0009);

        // ALU table: MVI R1,a; MVI R2,b; op R1,R2; 13 cycles
        vecs.push_back('{4'h5, 16'h0005, 16'h0003, 16'h0008});
        vecs.push_back('{4'h5, 16'hFFFF, 16'h0002, 16'h0001});
        vecs.push_back('{4'h6, 16'h0006, 16'h0005, 16'h0001});
        vecs.push_back('{4'h6, 16'h0003, 16'h0005, 16'hFFFE});
        vecs.push_back('{4'h7, 16'h00F0, 16'h0F0F, 16'h0FFF});
        vecs.push_back('{4'h8, 16'h0000, 16'h0001, 16'h0001});
        vecs.push_back('{4'h8, 16'hFFFF, 16'h0001, 16'h0000});
        vecs.push_back('{4'h8, 16'h0005, 16'h0005, 16'h0000});
        vecs.push_back('{4'h9, 16'h0003, 16'h0004, E_SLL_4});
        vecs.push_back('{4'h9, 16'h0001, 16'h0010, E_SLL_16});
        vecs.push_back('{4'hA, 16'h8000, 16'h000F, E_SRL_15});
        vecs.push_back('{4'hA, 16'h8000, 16'h0014, E_SRL_20});
        foreach (vecs[i]) begin
            prog = '{16'h0108, vecs[i].a, 16'h0110, vecs[i].b, {6'b000000, vecs[i].op, 6'b001010}};
            load_prog();
            restart();
            tick(13);
            check($sformatf("alu_vec%0d_r1", i), reg_of(1), vecs[i].exp);
            check($sformatf("alu_vec%0d_r2", i), reg_of(2), vecs[i].b);
        end

        // Random programs against the instruction-level model
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 256; i++) begin
                logic [15:0] v;
                v = 16'($urandom);
                ram[i] <= v;
                m_ram[i] = v;
                rom[i] = 16'($urandom);
            end
            for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
            m_g = 16'h0000;
            restart();
            for (int k = 0; k < 40; k++) begin
                model_exec(cyc);
                tick(cyc);
                for (int i = 0; i < 8; i++) exp_regs[16*i +: 16] = m_r[i];
                check($sformatf("rand_p%0d_i%0d", p, k), oREGS, exp_regs);
            end
            diffs = 0;
            for (int i = 0; i < 256; i++) if (ram[i] !== m_ram[i]) diffs++;
            check($sformatf("rand_p%0d_ram", p), diffs, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/proc_multicycle.md
PROC_MULTICYCLE -- requirements
Module: proc_multicycle

Interface
REQ-001 clk  in  1  system clock; all state changes on its rising edge.
REQ-002 Resetn  in  1  reset, asynchronous, active-high.
REQ-003 Run  in  1  start; high level sampled at clk rising edge sets the running flag.
REQ-004 DIN  in  16  instruction/immediate/load data from external memory.
REQ-005 ADDRout  out  16  memory address register output.
REQ-006 DOUTout  out  16  store data register output.
REQ-007 memW  out  1  memory write strobe, combinational, one cycle.
REQ-008 muxRomRam  out  1  combinational; 1 = DIN sourced from data RAM, 0 = from program ROM.
REQ-009 oREGS  out  128  {R7,R6,R5,R4,R3,R2,R1,R0}; R7 is the PC.
REQ-010 No parameters.

Function
REQ-011 Datapath: eight 16-bit registers R0–R7, A, G, ADDR, DOUT; 10-bit IR; one 16-bit bus; bus source priority DIN > G > selected Rn; no source selected drives 0.
REQ-012 IR[9:6] opcode, IR[5:3] X, IR[2:0] Y; X and Y decoded 3-to-8 one-hot into register enables and bus selects.
REQ-013 Step counter T0..T4 advances each cycle while running; Done or not-running returns it to T0 on the next edge.
REQ-014 T0 (all): ADDR<=R7, R7<=R7+1 (wraps 0xFFFF->0). T1 (all): IR<=DIN[9:0].
REQ-015 0 LD: T2 ADDR<=RY; T3 RX<=DIN, muxRomRam=1, Done (4 cycles).
REQ-016 1 ST: T2 ADDR<=RY; T3 DOUT<=RX; T4 memW=1, Done (5 cycles).
REQ-017 2 MVNZ: T2 if G!=0 then RX<=RY; Done (3 cycles).
REQ-018 3 MV: T2 RX<=RY, Done (3 cycles).
REQ-019 4 MVI: T2 ADDR<=R7, R7<=R7+1; T3 RX<=DIN, Done (4 cycles; immediate is next word).
REQ-020 5–A ALU: T2 A<=RX; T3 G<=A op RY; T4 RX<=G, Done (5 cycles).
REQ-021 ALU ops, 16-bit, carries discarded: 5 ADD A+B; 6 SUB A-B; 7 OR; 8 SLT unsigned (A<B)?1:0; 9 SLL A<<B; A SRL A>>B; shift amount >=16 yields 0.
REQ-022 Opcodes B–F: no operation, Done at T2 (3 cycles), no state change beyond T0/T1.
REQ-023 Writes to R7 by MV/MVNZ/LD/MVI/ALU take effect as a jump; R7 is the only register with +1 input.
REQ-024 memW and muxRomRam are 0 in every step not listed above.

Reset
REQ-025 Resetn high immediately clears running flag, step counter to T0, and all registers (R0–R7, A, G, IR, ADDR, DOUT) to 0; outputs: ADDRout=0, DOUTout=0, oREGS=0, memW=0, muxRomRam=0.
REQ-026 While Resetn high, Run ignored; reset mid-instruction aborts it with no partial write after assertion.
REQ-027 After reset, no step executes until Run is sampled high; running then stays set until next reset.

Configuration
REQ-028 Macro PROC_SHIFT_EN: defined -> SLL (9) and SRL (A) per REQ-020/021; undefined -> opcodes 9 and A behave as REQ-022 no-ops and shifter logic is absent.

Verification
REQ-029 Reset, Run=1, DIN: MVI R0 (0x0100), 2, MVI R1 (0x0108), 3, ADD R1,R0 (0x0148) -> R0=2, R1=5, R7=5 after 13 cycles.
REQ-030 R2=6, R1=5, SUB R2,R1 (0x0191) -> R2=1, G=1; then SLT R0,R1 with R0=0,R1=1 -> R0=1.
REQ-031 R3=3, LD R2,R3 (0x0013), DIN=4 at T3 -> ADDRout=3, muxRomRam=1 in T3 only, R2=4.
REQ-032 R2=7, R0=0, ST R2,R0 (0x0050) -> ADDRout=0, DOUTout=7, memW=1 in T4 only.
REQ-033 G=0 then MVNZ R0,R2 (0x0082) -> R0 unchanged, 3 cycles; after SUB giving G=2, same MVNZ -> R0=R2.
REQ-034 Resetn pulsed during T3 of ADD -> all outputs 0 immediately; execution resumes from address 0 once Run is high.
